// File: rtl/tile_match_engine.sv
// Memory tile-matching game core: holds the board and runs the reveal / compare /
// show / hide sequence for each pair of picks, tracking matches, pairs left and moves.
module tile_match_engine #(
    parameter int NUM_TILES   = 10,
    parameter int SYM_W       = 3,
    parameter int MOVE_W      = 8,
    parameter int SHOW_CYCLES = 50_000_000,
    localparam int IDX_W      = $clog2(NUM_TILES)
) (
    input  logic                 CLOCK_50,
    input  logic                 userquit,
    input  logic                 start,
    input  logic                 select,
    input  logic [IDX_W-1:0]     tile_idx,
    input  logic                 load_we,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [SYM_W-1:0]     load_sym,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic [MOVE_W-1:0]    move_count,
    output logic [IDX_W-1:0]     pairs_left,
    output logic                 in_game,
    output logic                 game_over,
    output logic [2:0]           state
);

    localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    // Handshake: start/select/load_we are single-cycle strobes sampled on the
    // rising edge; there is no ready, a strobe the current state cannot use is dropped.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT1   = 3'd1,
        WAIT2   = 3'd2,
        COMPARE = 3'd3,
        SHOW    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [SYM_W-1:0]     board [NUM_TILES];
    logic [IDX_W-1:0]     first_q, first_d, second_q, second_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NUM_TILES-1:0] revealed_d, matched_d;
    logic [MOVE_W-1:0]    move_d;
    logic [IDX_W-1:0]     pairs_d;

    logic                 idx_ok;
    logic [NUM_TILES-1:0] sel_mask, first_mask, second_mask;
    logic                 sel_valid;
    logic                 load_ok;

    assign idx_ok      = (int'(tile_idx) < NUM_TILES);
    assign sel_mask    = idx_ok ? (NUM_TILES'(1) << tile_idx) : '0;
    assign sel_valid   = select && idx_ok && ((matched & sel_mask) == '0);
    assign first_mask  = NUM_TILES'(1) << first_q;
    assign second_mask = NUM_TILES'(1) << second_q;
    assign load_ok     = load_we && (state_q == IDLE) && (int'(load_idx) < NUM_TILES);

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        second_d   = second_q;
        timer_d    = timer_q;
        revealed_d = revealed;
        matched_d  = matched;
        move_d     = move_count;
        pairs_d    = pairs_left;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = WAIT1;
                    revealed_d = '0;
                    matched_d  = '0;
                    move_d     = '0;
                    pairs_d    = IDX_W'(NUM_TILES / 2);
                end
            end
            WAIT1: begin
                if (sel_valid) begin
                    revealed_d = revealed | sel_mask;
                    first_d    = tile_idx;
                    state_d    = WAIT2;
                end
            end
            WAIT2: begin
                if (sel_valid && (tile_idx != first_q)) begin
                    revealed_d = revealed | sel_mask;
                    second_d   = tile_idx;
                    if (move_count != '1) move_d = move_count + MOVE_W'(1);
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                if (board[first_q] == board[second_q]) begin
                    matched_d  = matched | first_mask | second_mask;
                    revealed_d = revealed & ~(first_mask | second_mask);
                    pairs_d    = pairs_left - IDX_W'(1);
                    state_d    = (pairs_left == IDX_W'(1)) ? DONE : WAIT1;
                end else begin
                    timer_d = TMR_W'(SHOW_CYCLES - 1);
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (timer_q == '0) begin
                    revealed_d = revealed & ~(first_mask | second_mask);
                    state_d    = WAIT1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state_q    <= IDLE;
            first_q    <= '0;
            second_q   <= '0;
            timer_q    <= '0;
            revealed   <= '0;
            matched    <= '0;
            move_count <= '0;
            pairs_left <= '0;
            in_game    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            second_q   <= second_d;
            timer_q    <= timer_d;
            revealed   <= revealed_d;
            matched    <= matched_d;
            move_count <= move_d;
            pairs_left <= pairs_d;
            in_game    <= (state_d == WAIT1) || (state_d == WAIT2) ||
                          (state_d == COMPARE) || (state_d == SHOW);
            game_over  <= (state_d == DONE);
        end
    end

    // Board contents survive reset so a quit game can be restarted on the same layout.
    always_ff @(posedge CLOCK_50) begin
        if (!userquit && load_ok) board[load_idx] <= load_sym;
    end

    assign state = state_q;

endmodule

// File: tb/tb_tile_match_engine.sv
// Directed bench for tile_match_engine: a table of per-cycle vectors plus
// hand-written sequences for mismatch saturation and quit-during-show.
module tb_tile_match_engine;

  localparam int NT = 6;
  localparam int SW = 3;
  localparam int MW = 2;
  localparam int SC = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          userquit = 1'b0, start = 1'b0, select = 1'b0, load_we = 1'b0;
  logic [IW-1:0] tile_idx = '0, load_idx = '0;
  logic [SW-1:0] load_sym = '0;
  logic [NT-1:0] revealed, matched;
  logic [MW-1:0] move_count;
  logic [IW-1:0] pairs_left;
  logic          in_game, game_over;
  logic [2:0]    state;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  tile_match_engine #(
    .NUM_TILES(NT), .SYM_W(SW), .MOVE_W(MW), .SHOW_CYCLES(SC)
  ) dut (
    .CLOCK_50(clk), .userquit(userquit), .start(start), .select(select),
    .tile_idx(tile_idx), .load_we(load_we), .load_idx(load_idx), .load_sym(load_sym),
    .revealed(revealed), .matched(matched), .move_count(move_count),
    .pairs_left(pairs_left), .in_game(in_game), .game_over(game_over), .state(state)
  );

  typedef struct {
    logic          quit, st_p, sel;
    logic [IW-1:0] idx;
    logic          we;
    logic [IW-1:0] widx;
    logic [SW-1:0] wsym;
    logic [2:0]    st;
    logic [NT-1:0] rev, mat;
    logic [MW-1:0] mv;
    logic [IW-1:0] pairs;
    logic          go;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic quit, st_p, sel, input int idx,
                              input logic we, input int widx, input int wsym,
                              input int st, input logic [NT-1:0] rev, mat,
                              input int mv, input int pairs, input logic go);
    vec_t v;
    v.quit = quit; v.st_p = st_p; v.sel = sel; v.idx = IW'(idx);
    v.we = we; v.widx = IW'(widx); v.wsym = SW'(wsym);
    v.st = 3'(st); v.rev = rev; v.mat = mat; v.mv = MW'(mv);
    v.pairs = IW'(pairs); v.go = go;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic exp_in_game;
    userquit = v.quit; start = v.st_p; select = v.sel; tile_idx = v.idx;
    load_we = v.we; load_idx = v.widx; load_sym = v.wsym;
    @(posedge clk);
    #1;
    userquit = 1'b0; start = 1'b0; select = 1'b0; load_we = 1'b0;
    exp_in_game = (v.st >= 3'd1) && (v.st <= 3'd4);
    chk({tag, " state"}, 32'(state), 32'(v.st));
    chk({tag, " revealed"}, 32'(revealed), 32'(v.rev));
    chk({tag, " matched"}, 32'(matched), 32'(v.mat));
    chk({tag, " move_count"}, 32'(move_count), 32'(v.mv));
    chk({tag, " pairs_left"}, 32'(pairs_left), 32'(v.pairs));
    chk({tag, " game_over"}, 32'(game_over), 32'(v.go));
    chk({tag, " in_game"}, 32'(in_game), 32'(exp_in_game));
  endtask

  initial begin
    int syms[NT] = '{5, 2, 5, 2, 1, 1};
    int e;

    // Reset and board load (index 7 is out of range and must be dropped).
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0));
    for (int i = 0; i < NT; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, i, syms[i], 0, 6'b0, 6'b0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 5, 0, 6'b0, 6'b0, 0, 0, 0));
    // Full game with illegal picks mixed in.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 6'b000001, 6'b000000, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 6'b000001, 6'b000000, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 7, 0, 0, 0, 2, 6'b000001, 6'b000000, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0, 3, 6'b000101, 6'b000000, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b000101, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0, 1, 6'b000000, 6'b000101, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2, 6'b000010, 6'b000101, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 3, 0, 0, 0, 3, 6'b001010, 6'b000101, 2, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b001111, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b001111, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 2, 6'b010000, 6'b001111, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0, 3, 6'b110000, 6'b001111, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 6'b000000, 6'b111111, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 6'b000000, 6'b111111, 3, 0, 1));
    // Restart from DONE, then a mismatch with a select during SHOW.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 6'b000001, 6'b000000, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3, 6'b000011, 6'b000000, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 6'b000011, 6'b000000, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 4, 6'b000011, 6'b000000, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 6'b000011, 6'b000000, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 1, 3, 0));

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Further mismatches: move_count must stick at 3.
    for (int k = 2; k <= 4; k++) begin
      e = (k > 3) ? 3 : k;
      apply(mk(0, 0, 1, 0, 0, 0, 0, 2, 6'b000001, 6'b0, (k - 1 > 3) ? 3 : k - 1, 3, 0),
            $sformatf("sat%0d_pick0", k));
      apply(mk(0, 0, 1, 1, 0, 0, 0, 3, 6'b000011, 6'b0, e, 3, 0), $sformatf("sat%0d_pick1", k));
      for (int c = 0; c < SC; c++)
        apply(mk(0, 0, 0, 0, 0, 0, 0, 4, 6'b000011, 6'b0, e, 3, 0),
              $sformatf("sat%0d_show%0d", k, c));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b0, e, 3, 0), $sformatf("sat%0d_hide", k));
    end

    // Fifth attempt, then quit in the middle of SHOW.
    apply(mk(0, 0, 1, 0, 0, 0, 0, 2, 6'b000001, 6'b0, 3, 3, 0), "sat5_pick0");
    apply(mk(0, 0, 1, 1, 0, 0, 0, 3, 6'b000011, 6'b0, 3, 3, 0), "sat5_pick1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 4, 6'b000011, 6'b0, 3, 3, 0), "sat5_show");
    apply(mk(1, 0, 1, 2, 0, 0, 0, 0, 6'b000000, 6'b0, 0, 0, 0), "quit_show");

    // Start with a same-edge write of tile 3 to symbol 1; tile 4 keeps symbol 1.
    apply(mk(0, 1, 0, 0, 1, 3, 1, 1, 6'b000000, 6'b000000, 0, 3, 0), "restart_load");
    apply(mk(0, 0, 1, 4, 0, 0, 0, 2, 6'b010000, 6'b000000, 0, 3, 0), "retain_pick4");
    apply(mk(0, 0, 1, 3, 0, 0, 0, 3, 6'b011000, 6'b000000, 1, 3, 0), "retain_pick3");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 6'b011000, 1, 2, 0), "retain_match");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
